// File: rtl/pipe_ctrl_pkg.sv
// Shared types and action encodings for the 5-stage pipeline sequencer.
// Each action is an (enable, clear) pair for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_DONE = 2'd2,
    HALT     = 2'd3
  } pc_state_t;

  localparam int STG_PC  = 0;
  localparam int STG_IF  = 1;
  localparam int STG_ID  = 2;
  localparam int STG_EX  = 3;
  localparam int STG_WB  = 4;

  typedef struct packed {
    logic [4:0] en;
    logic [4:0] clr;
  } stage_act_t;

  localparam stage_act_t ACT_ADV    = '{en: 5'b11111, clr: 5'b00000};
  localparam stage_act_t ACT_FLUSH  = '{en: 5'b11111, clr: 5'b01110};
  localparam stage_act_t ACT_LDUSE  = '{en: 5'b11100, clr: 5'b00100};
  localparam stage_act_t ACT_FREEZE = '{en: 5'b10000, clr: 5'b10000};
  localparam stage_act_t ACT_HOLD   = '{en: 5'b00000, clr: 5'b00000};

  // Held on the stage controls while rst_n is low: nothing advances, all
  // pipeline registers are bubbled.
  localparam stage_act_t ACT_RESET  = '{en: 5'b00000, clr: 5'b11110};

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard-request / stage-control bundle between hazardUnit, the sequencer
// and the pipeline registers.
interface pipeline_ctrl_if;
  logic       stall_req;
  logic       branch_taken;
  logic       mem_req;
  logic [4:0] stage_en;
  logic [4:0] stage_clr;

  modport master (
    output stall_req, branch_taken, mem_req,
    input  stage_en, stage_clr
  );

  modport slave (
    input  stall_req, branch_taken, mem_req,
    output stage_en, stage_clr
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear that takes priority over
// increment.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update
  // together from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: merges hazard requests, data-memory wait states and
// debug halt/step into PC / pipeline-register enables and clears.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_LAT = 2,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  pipeline_ctrl_if.slave    pipe,
  input  logic              halt,
  input  logic              step,
  input  logic              cnt_clr,
  output logic [1:0]        state_o,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  // Counter for the MEM_WAIT cycles between the first and last freeze cycle.
  localparam int WAIT_W    = (MEM_LAT > 2) ? $clog2(MEM_LAT) : 1;
  localparam int WAIT_INIT = (MEM_LAT > 2) ? (MEM_LAT - 3) : 0;

  pc_state_t   state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  stage_act_t  act;
  logic        is_flush;
  logic        stall_inc;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    act        = ACT_HOLD;
    is_flush   = 1'b0;

    if (state_q == MEM_WAIT) begin
      act = ACT_FREEZE;
      if (wait_cnt_q != '0) begin
        wait_cnt_d = wait_cnt_q - WAIT_W'(1);
      end else begin
        state_d = MEM_DONE;
      end
    end else begin
      // RUN, MEM_DONE and HALT all settle in HALT or RUN depending on halt;
      // a freeze overrides that by entering the memory wait sequence.
      state_d = halt ? HALT : RUN;
      if ((state_q == HALT) && !step) begin
        act = ACT_HOLD;
      end else if (pipe.branch_taken) begin
        act      = ACT_FLUSH;
        is_flush = 1'b1;
      end else if (pipe.mem_req && (MEM_LAT > 1) && (state_q != MEM_DONE)) begin
        act        = ACT_FREEZE;
        state_d    = (MEM_LAT > 2) ? MEM_WAIT : MEM_DONE;
        wait_cnt_d = WAIT_W'(WAIT_INIT);
      end else if (pipe.stall_req) begin
        act = ACT_LDUSE;
      end else begin
        act = ACT_ADV;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Reset overrides the stage controls combinationally so an in-flight
  // memory wait is abandoned the moment rst_n falls.
  assign pipe.stage_en  = rst_n ? act.en  : ACT_RESET.en;
  assign pipe.stage_clr = rst_n ? act.clr : ACT_RESET.clr;
  assign state_o        = state_q;

  assign stall_inc = !act.en[STG_PC] && (state_q != HALT);

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc),
    .clr   (cnt_clr),
    .cnt   (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (is_flush),
    .clr   (cnt_clr),
    .cnt   (flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: three instances (MEM_LAT 4/2/1) share one
// stimulus set; each test checks the instance whose parameters it targets.
module tb_pipeline_ctrl;

  logic clk;
  logic rst_n;
  logic stall_req, branch_taken, mem_req;
  logic halt, step, cnt_clr;

  int n_checks = 0;
  int n_errors = 0;

  pipeline_ctrl_if if4 ();
  pipeline_ctrl_if if2 ();
  pipeline_ctrl_if if1 ();

  assign if4.stall_req = stall_req;  assign if4.branch_taken = branch_taken;  assign if4.mem_req = mem_req;
  assign if2.stall_req = stall_req;  assign if2.branch_taken = branch_taken;  assign if2.mem_req = mem_req;
  assign if1.stall_req = stall_req;  assign if1.branch_taken = branch_taken;  assign if1.mem_req = mem_req;

  logic [1:0]  st4, st2, st1;
  logic [15:0] sc4, fc4, sc1, fc1;
  logic [3:0]  sc2, fc2;

  pipeline_ctrl #(.MEM_LAT(4), .CNT_W(16)) u4 (
    .clk(clk), .rst_n(rst_n), .pipe(if4), .halt(halt), .step(step), .cnt_clr(cnt_clr),
    .state_o(st4), .stall_cnt(sc4), .flush_cnt(fc4)
  );
  pipeline_ctrl #(.MEM_LAT(2), .CNT_W(4)) u2 (
    .clk(clk), .rst_n(rst_n), .pipe(if2), .halt(halt), .step(step), .cnt_clr(cnt_clr),
    .state_o(st2), .stall_cnt(sc2), .flush_cnt(fc2)
  );
  pipeline_ctrl #(.MEM_LAT(1), .CNT_W(16)) u1 (
    .clk(clk), .rst_n(rst_n), .pipe(if1), .halt(halt), .step(step), .cnt_clr(cnt_clr),
    .state_o(st1), .stall_cnt(sc1), .flush_cnt(fc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Advance one clock and sample 1 ns after the rising edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_inputs();
    stall_req = 0; branch_taken = 0; mem_req = 0;
    halt = 0; step = 0; cnt_clr = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    tick();
    rst_n = 1;
    #1;
  endtask

  initial begin
    clear_inputs();
    rst_n = 0;
    #1;
    check("rst_en", 32'(if4.stage_en), 32'h00);
    check("rst_clr", 32'(if4.stage_clr), 32'h1E);
    tick(2);
    rst_n = 1;
    #1;
    check("init_state", 32'(st4), 32'd0);
    check("init_en", 32'(if4.stage_en), 32'h1F);
    check("init_clr", 32'(if4.stage_clr), 32'h00);
    check("init_stall_cnt", 32'(sc4), 32'd0);
    check("init_flush_cnt", 32'(fc4), 32'd0);

    // T2 load-use
    stall_req = 1;
    #1;
    check("lduse_en", 32'(if4.stage_en), 32'h1C);
    check("lduse_clr", 32'(if4.stage_clr), 32'h04);
    tick();
    stall_req = 0;
    #1;
    check("lduse_stall_cnt", 32'(sc4), 32'd1);
    check("lduse_next_en", 32'(if4.stage_en), 32'h1F);
    check("lduse_next_clr", 32'(if4.stage_clr), 32'h00);

    // T3 memory wait, MEM_LAT=4 and MEM_LAT=1
    do_reset();
    mem_req = 1;
    #1;
    check("mem_c0_en", 32'(if4.stage_en), 32'h10);
    check("mem_c0_clr", 32'(if4.stage_clr), 32'h10);
    check("mem_lat1_en", 32'(if1.stage_en), 32'h1F);
    tick();
    check("mem_c1_state", 32'(st4), 32'd1);
    check("mem_c1_en", 32'(if4.stage_en), 32'h10);
    tick();
    check("mem_c2_state", 32'(st4), 32'd1);
    check("mem_c2_en", 32'(if4.stage_en), 32'h10);
    tick();
    check("mem_done_state", 32'(st4), 32'd2);
    check("mem_done_en", 32'(if4.stage_en), 32'h1F);
    check("mem_stall_cnt", 32'(sc4), 32'd3);
    check("mem_lat1_stall_cnt", 32'(sc1), 32'd0);
    mem_req = 0;
    tick();
    check("mem_back_run", 32'(st4), 32'd0);

    // T1 reset mid-MEM_WAIT
    mem_req = 1;
    tick();
    mem_req = 0;
    #1;
    check("t1_in_wait", 32'(st4), 32'd1);
    rst_n = 0;
    #1;
    check("t1_rst_en", 32'(if4.stage_en), 32'h00);
    check("t1_rst_clr", 32'(if4.stage_clr), 32'h1E);
    check("t1_rst_state", 32'(st4), 32'd0);
    tick();
    rst_n = 1;
    #1;
    check("t1_rel_en", 32'(if4.stage_en), 32'h1F);
    check("t1_rel_stall_cnt", 32'(sc4), 32'd0);
    tick();
    check("t1_rel_state", 32'(st4), 32'd0);

    // T4 branch flush beats load-use
    do_reset();
    stall_req = 1; branch_taken = 1;
    #1;
    check("flush_en", 32'(if4.stage_en), 32'h1F);
    check("flush_clr", 32'(if4.stage_clr), 32'h0E);
    tick();
    clear_inputs();
    #1;
    check("flush_cnt", 32'(fc4), 32'd1);
    check("flush_stall_cnt", 32'(sc4), 32'd0);

    // T5 debug halt / step on MEM_LAT=2
    do_reset();
    halt = 1;
    #1;
    check("halt_entry_en", 32'(if2.stage_en), 32'h1F);
    tick();
    check("halt_state", 32'(st2), 32'd3);
    check("halt_en", 32'(if2.stage_en), 32'h00);
    check("halt_clr", 32'(if2.stage_clr), 32'h00);
    stall_req = 1;
    tick(2);
    check("halt_hold_en", 32'(if2.stage_en), 32'h00);
    check("halt_stall_cnt", 32'(sc2), 32'd0);
    stall_req = 0;
    step = 1; mem_req = 1;
    #1;
    check("step_freeze_en", 32'(if2.stage_en), 32'h10);
    check("step_freeze_clr", 32'(if2.stage_clr), 32'h10);
    tick();
    step = 0;
    #1;
    check("step_done_state", 32'(st2), 32'd2);
    check("step_done_en", 32'(if2.stage_en), 32'h1F);
    tick();
    mem_req = 0;
    #1;
    check("step_back_halt", 32'(st2), 32'd3);
    check("step_stall_cnt", 32'(sc2), 32'd0);
    halt = 0;
    #1;
    check("unhalt_hold_en", 32'(if2.stage_en), 32'h00);
    tick();
    check("unhalt_state", 32'(st2), 32'd0);
    check("unhalt_en", 32'(if2.stage_en), 32'h1F);

    // T6 saturation on CNT_W=4
    do_reset();
    stall_req = 1;
    tick(14);
    check("sat_14", 32'(sc2), 32'd14);
    tick(6);
    check("sat_20", 32'(sc2), 32'd15);
    cnt_clr = 1;
    tick();
    check("sat_clr", 32'(sc2), 32'd0);
    cnt_clr = 0;
    tick();
    check("sat_after_clr", 32'(sc2), 32'd1);
    clear_inputs();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
